// File: rtl/seq_mult_pkg.sv
// Shared definitions for the seq_mult shift-add multiplier: FSM encoding and default widths.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam int DEF_WIDTH = 16;
    localparam int PW        = 2 * DEF_WIDTH;

endpackage

// File: rtl/seq_mult_cla.sv
// N-bit adder: 1-bit carry-lookahead cells whose group carries ripple through the p/g terms.
module cla_adder_nbit #(
    parameter int N = 32
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic [N-1:0] Sum,
    output logic         Cout
);

    logic [N-1:0] p_s;
    logic [N-1:0] g_s;
    logic [N:0]   c_s;

    assign c_s[0] = Cin;

    for (genvar i = 0; i < N; i++) begin : g_cell
        assign p_s[i]   = A[i] ^ B[i];
        assign g_s[i]   = A[i] & B[i];
        assign c_s[i+1] = g_s[i] | (p_s[i] & c_s[i]);
        assign Sum[i]   = p_s[i] ^ c_s[i];
    end

    assign Cout = c_s[N];

endmodule

// File: rtl/seq_mult.sv
// Sequential unsigned shift-add multiplier with start/busy/done handshake.
// Optional macro SEQ_MULT_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are zero.
module seq_mult
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic               hi_nz
);

    localparam int PROD_W = 2 * WIDTH;

    state_t              state_q,   state_d;
    logic [PROD_W-1:0]   acc_q,     acc_d;
    logic [PROD_W-1:0]   mcand_q,   mcand_d;
    logic [WIDTH-1:0]    mplier_q,  mplier_d;
    logic [CNT_W-1:0]    cnt_q,     cnt_d;
    logic                busy_q,    busy_d;
    logic                done_q,    done_d;
    logic [PROD_W-1:0]   product_q, product_d;
    logic                hi_nz_q,   hi_nz_d;

    logic [PROD_W-1:0]   sum_s;
    logic                add_cout_s;
    logic                last_iter_s;

    // Carry-out is never set for an unsigned WIDTH x WIDTH product and is dropped.
    cla_adder_nbit #(.N(PROD_W)) u_add (
        .A    (acc_q),
        .B    (mcand_q),
        .Cin  (1'b0),
        .Sum  (sum_s),
        .Cout (add_cout_s)
    );

`ifdef SEQ_MULT_EARLY_TERM_EN
    assign last_iter_s = (mplier_q[WIDTH-1:1] == '0);
`else
    assign last_iter_s = (cnt_q == CNT_W'(WIDTH - 1));
`endif

    // Next-state and datapath computation.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        hi_nz_d   = hi_nz_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    acc_d    = '0;
                    mcand_d  = {{WIDTH{1'b0}}, op_a};
                    mplier_d = op_b;
                    cnt_d    = '0;
`ifdef SEQ_MULT_EARLY_TERM_EN
                    if (op_b == '0) begin
                        state_d   = ST_DONE;
                        product_d = '0;
                        hi_nz_d   = 1'b0;
                    end else begin
                        state_d = ST_BUSY;
                    end
`else
                    state_d = ST_BUSY;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (mplier_q[0]) begin
                    acc_d = sum_s;
                end else begin
                    acc_d = acc_q;
                end
                mcand_d  = {mcand_q[PROD_W-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CNT_W'(1);
                // Product is captured on the way into DONE so it is valid alongside done.
                if (last_iter_s) begin
                    state_d   = ST_DONE;
                    product_d = acc_d;
                    hi_nz_d   = |acc_d[PROD_W-1:WIDTH];
                end else begin
                    state_d = ST_BUSY;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_BUSY);
        done_d = (state_d == ST_DONE);
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
            hi_nz_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
            hi_nz_q   <= hi_nz_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;
    assign hi_nz   = hi_nz_q;

endmodule

// File: tb/tb_seq_mult.sv
// Self-checking bench for seq_mult: directed cases plus random operands against an arithmetic model.
module tb_seq_mult;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] product;
    logic        hi_nz;

    int vectors;
    int miscompares;

    seq_mult dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op_a    (op_a),
        .op_b    (op_b),
        .busy    (busy),
        .done    (done),
        .product (product),
        .hi_nz   (hi_nz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Edges from the accepting edge E0 until the edge that first sees done high.
    function automatic int model_latency(input logic [15:0] b);
`ifdef SEQ_MULT_EARLY_TERM_EN
        if (b == 16'd0) return 1;
        for (int i = 15; i >= 0; i--) begin
            if (b[i]) return i + 2;
        end
        return 1;
`else
        return 17;
`endif
    endfunction

    // Drive start with operands; returns at #1 after E0 with start dropped.
    task automatic launch(input logic [15:0] a, input logic [15:0] b);
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        op_a  = 16'($urandom);
        op_b  = 16'($urandom);
    endtask

    // Waits for done after launch; returns at #1 inside the done cycle.
    task automatic wait_done(input string tag, input logic [15:0] a, input logic [15:0] b,
                             input bit glitch);
        logic [31:0] exp_p;
        int          lat;
        int          n;
        exp_p = 32'(a) * 32'(b);
        lat   = model_latency(b);
        n     = 0;
        while (done !== 1'b1 && n < 40) begin
            chk({tag, "_busy"}, 64'(busy), 64'd1);
            if (glitch && lat >= 8 && n == 3) begin
                start = 1'b1;
                op_a  = 16'($urandom);
                op_b  = 16'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b0;
        chk({tag, "_lat"}, 64'(n + 1), 64'(lat));
        chk({tag, "_busy_lo"}, 64'(busy), 64'd0);
        chk({tag, "_prod"}, 64'(product), 64'(exp_p));
        chk({tag, "_hinz"}, 64'(hi_nz), 64'(exp_p[31:16] != 16'd0));
    endtask

    // One full isolated multiply, including the one-cycle done pulse and held product.
    task automatic mult(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input bit glitch);
        logic [31:0] exp_p;
        exp_p = 32'(a) * 32'(b);
        launch(a, b);
        wait_done(tag, a, b, glitch);
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, 64'(done), 64'd0);
        chk({tag, "_hold"}, 64'(product), 64'(exp_p));
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        op_a        = 16'd0;
        op_b        = 16'd0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_prod", 64'(product), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk("idle_busy", 64'(busy), 64'd0);
            chk("idle_done", 64'(done), 64'd0);
            chk("idle_prod", 64'(product), 64'd0);
        end

        mult("basic", 16'h0003, 16'h0005, 1'b0);
        mult("ovf_ffff", 16'hFFFF, 16'hFFFF, 1'b0);
        mult("ovf_0100", 16'h0100, 16'h0100, 1'b0);
        mult("zero_b", 16'hABCD, 16'h0000, 1'b0);
        mult("zero_a", 16'h0000, 16'hBEEF, 1'b0);
        mult("msb_b", 16'h0003, 16'h8000, 1'b0);
        mult("ignore", 16'h1357, 16'hF00D, 1'b1);

        // Back-to-back: new start accepted in the DONE cycle.
        launch(16'h00FF, 16'hC001);
        wait_done("b2b_first", 16'h00FF, 16'hC001, 1'b0);
        launch(16'h1234, 16'h0002);
        wait_done("b2b_second", 16'h1234, 16'h0002, 1'b0);
        @(posedge clk);
        #1;

        // Reset in the middle of an operation aborts without done.
        launch(16'h4321, 16'hFFFF);
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_prod", 64'(product), 64'd0);
        chk("midrst_hinz", 64'(hi_nz), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk("midrst_nodone", 64'(done), 64'd0);
        end
        mult("after_rst", 16'd7, 16'd6, 1'b0);

        // Random operands, some chained back-to-back.
        for (int i = 0; i < 24; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            case ($urandom_range(0, 3))
                0: rb = 16'($urandom_range(0, 15));
                1: ra = 16'hFFFF;
                default: ;
            endcase
            launch(ra, rb);
            wait_done("rand", ra, rb, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 0) begin
                @(posedge clk);
                #1;
                chk("rand_pulse", 64'(done), 64'd0);
            end
        end
        @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
